imem_prog_loader: RTL and testbench

//  Hardware boot loader for the 16-bit CPU instruction memory. It receives a framed program as a byte

---
 rtl/imem_prog_loader.sv | 118 +++++++++++
 tb/tb_imem_prog_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog_loader.sv
// Boot loader: receives a framed byte stream (SYNC, N, N x {hi,lo}, CHK) and writes 16-bit words
// into instruction memory, holding the CPU in reset until a frame with a good checksum arrives.
module imem_prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_nreset,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_HDR, S_CNT, S_HI, S_LO, S_WR, S_CHK, S_RUN, S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_n;
    logic [7:0]          r_idx;
    logic [7:0]          r_acc;
    logic [7:0]          r_hi;
    logic                r_rx_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic                r_cpu_nreset;
    logic                r_done;
    logic                r_err;
    logic                w_xfer;
    logic [7:0]          w_idx_inc;

    assign w_xfer    = rx_valid & r_rx_ready;
    assign w_idx_inc = r_idx + 8'd1;

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_nreset = r_cpu_nreset;
    assign done       = r_done;
    assign err        = r_err;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) r_state <= S_HDR;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR: if (w_xfer && rx_data == SYNC_BYTE) w_state_nxt = S_CNT;
            S_CNT: if (w_xfer) w_state_nxt = (rx_data == 8'd0) ? S_CHK : S_HI;
            S_HI:  if (w_xfer) w_state_nxt = S_LO;
            S_LO:  if (w_xfer) w_state_nxt = S_WR;
            S_WR:  w_state_nxt = (w_idx_inc == r_n) ? S_CHK : S_HI;
            S_CHK: if (w_xfer) w_state_nxt = (rx_data == r_acc) ? S_RUN : S_ERR;
            S_RUN: if (load_req) w_state_nxt = S_HDR;
            // load_req takes priority over a byte arriving in the same cycle
            S_ERR: begin
                if (load_req)                              w_state_nxt = S_HDR;
                else if (w_xfer && rx_data == SYNC_BYTE)   w_state_nxt = S_CNT;
            end
            default: w_state_nxt = S_HDR;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_n          <= 8'd0;
            r_idx        <= 8'd0;
            r_acc        <= 8'd0;
            r_hi         <= 8'd0;
            r_rx_ready   <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 16'd0;
            r_cpu_nreset <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rx_ready   <= !(w_state_nxt == S_WR || w_state_nxt == S_RUN);
            r_we         <= (w_state_nxt == S_WR);
            r_cpu_nreset <= (w_state_nxt == S_RUN);
            r_done       <= (w_state_nxt == S_RUN);
            case (r_state)
                S_CNT: if (w_xfer) begin
                    r_n   <= rx_data;
                    r_acc <= rx_data;
                    r_idx <= 8'd0;
                end
                S_HI: if (w_xfer) begin
                    r_hi  <= rx_data;
                    r_acc <= r_acc ^ rx_data;
                end
                S_LO: if (w_xfer) begin
                    r_acc   <= r_acc ^ rx_data;
                    r_wdata <= {r_hi, rx_data};
                    r_addr  <= ADDR_W'(r_idx);
                end
                S_WR:  r_idx <= w_idx_inc;
                S_CHK: if (w_xfer) r_err <= (rx_data != r_acc);
                S_ERR: if (!load_req && w_xfer && rx_data == SYNC_BYTE) r_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Randomized bench for imem_prog_loader: frames are built from word lists, expected imem writes are
// queued per frame and a separate monitor compares every imem_we pulse against that queue.
module tb_imem_prog_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              nRESET = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              load_req = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_nreset;
    logic              done;
    logic              err;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [15:0] words[256];
    bit          running = 1'b0;
    bit          gaps_on = 1'b1;

    imem_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .nRESET(nRESET), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_nreset(cpu_nreset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", imem_addr, imem_wdata);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("imem_write", {8'h00, imem_addr, imem_wdata}, {8'h00, e});
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"},   rx_ready,   1);
        check({tag, "_imem_we"},    imem_we,    0);
        check({tag, "_imem_addr"},  imem_addr,  0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_cpu_nreset"}, cpu_nreset, 0);
        check({tag, "_done"},       done,       0);
        check({tag, "_err"},        err,        0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cnt = 0;
        if (gaps_on) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 40) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout actual=0 required=1");
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check("load_cpu_nreset", cpu_nreset, 0);
        check("load_done",       done,       0);
        check("load_rx_ready",   rx_ready,   1);
        running = 1'b0;
    endtask

    task automatic send_junk(input int nj);
        for (int i = 0; i < nj; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
        end
    endtask

    // Reference: checksum is XOR of N and every data byte; word i lands at address i.
    task automatic send_frame(input int n, input bit bad, input int nj);
        logic [7:0] acc;
        logic [7:0] chk;
        if (running) pulse_load();
        send_junk(nj);
        acc = 8'(n);
        for (int i = 0; i < n; i++) begin
            acc = acc ^ words[i][15:8] ^ words[i][7:0];
            exp_q.push_back({8'(i), words[i]});
        end
        chk = bad ? (acc ^ 8'($urandom_range(1, 255))) : acc;
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8]);
            send_byte(words[i][7:0]);
        end
        send_byte(chk);
        check("writes_drained", exp_q.size(), 0);
        exp_q.delete();
        check("frame_done",       done,       !bad);
        check("frame_err",        err,        bad);
        check("frame_cpu_nreset", cpu_nreset, !bad);
        check("frame_rx_ready",   rx_ready,   bad);
        running = !bad;
    endtask

    task automatic rand_words(input int n);
        for (int i = 0; i < n; i++) words[i] = 16'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("in_reset");
        nRESET = 1'b1;
        @(posedge clk);
        #1;
        check_reset("after_release");

        // Basic three-word frame, then the same frame with a corrupted checksum, then recovery.
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0001;
        send_frame(3, 1'b0, 0);
        send_frame(3, 1'b1, 0);
        send_frame(3, 1'b0, 0);

        // Leading junk bytes are discarded in HDR.
        pulse_load();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        words[0] = 16'hBEEF;
        send_frame(1, 1'b0, 0);

        // In RUN, incoming bytes are ignored.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        check("run_ignore_done",     done,     1);
        check("run_ignore_rx_ready", rx_ready, 0);

        // Empty frame.
        send_frame(0, 1'b0, 0);
        pulse_load();

        // Async reset in the middle of a 4-word frame.
        rand_words(4);
        exp_q.push_back({8'd0, words[0]});
        exp_q.push_back({8'd1, words[1]});
        send_byte(8'hA5); send_byte(8'h04);
        for (int i = 0; i < 2; i++) begin
            send_byte(words[i][15:8]);
            send_byte(words[i][7:0]);
        end
        @(posedge clk);
        #2;
        nRESET = 1'b0;
        #1;
        check_reset("mid_frame_reset");
        check("mid_frame_writes", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        nRESET = 1'b1;
        running = 1'b0;
        rand_words(4);
        send_frame(4, 1'b0, 0);

        // Back-to-back bytes, including a maximum-length frame.
        gaps_on = 1'b0;
        rand_words(10);
        send_frame(10, 1'b0, 0);
        rand_words(255);
        send_frame(255, 1'b0, 0);

        // Randomized frames with random gaps, junk and checksum errors.
        for (int k = 0; k < 10; k++) begin
            int n;
            bit bad;
            gaps_on = ($urandom_range(0, 1) == 1);
            n   = $urandom_range(0, 16);
            bad = ($urandom_range(0, 3) == 0);
            rand_words(n);
            send_frame(n, bad, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
